// File: rtl/mem_responder.sv
// mem_responder: single-word memory responder with programmable wait states.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the accepting edge; one request in flight.
// Backpressure: req is sampled only in IDLE; requests arriving while busy are dropped, not queued.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   req, wr          request strobe, 1 = write / 0 = read
//   addr, wdata      byte address (word index = addr[ADDR_W+1:2]), write data
//   rdata            last read data, updated only by good reads
//   ready, err       one-cycle completion pulse, misaligned-access flag (valid with ready)
//   busy             high from the accepting edge through the response cycle
// Optional feature macro: MEM_RESPONDER_BYTE_EN adds be[3:0] byte-lane write enables.

module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef MEM_RESPONDER_BYTE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                wr_q;
  logic                bad_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [3:0]          lane_q;

  logic [31:0]         mem [2**ADDR_W];

  logic [3:0]          lane_now;
  logic                bad_now;
  logic [ADDR_W-1:0]   acc_idx;
  logic                acc_wr;
  logic                acc_bad;

  // Address bits above the word index are don't-care: accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

`ifdef MEM_RESPONDER_BYTE_EN
  assign lane_now = be;
  // Legal shapes: full word at offset 0, half word at even offset,
  // or a single byte whose lane matches the byte offset.
  always_comb begin
    bad_now = 1'b1;
    if (be == 4'b1111 && addr[1:0] == 2'b00)
      bad_now = 1'b0;
    else if ((be == 4'b0011 || be == 4'b1100) && !addr[0])
      bad_now = 1'b0;
    else if (be == (4'b0001 << addr[1:0]))
      bad_now = 1'b0;
  end
`else
  assign lane_now = 4'b1111;
  assign bad_now  = (addr[1:0] != 2'b00);
`endif

  // When entering RESP straight from IDLE (zero wait states) the request
  // is not yet latched, so look at the live inputs instead.
  assign acc_idx = (state == IDLE) ? addr[ADDR_W+1:2] : idx_q;
  assign acc_wr  = (state == IDLE) ? wr               : wr_q;
  assign acc_bad = (state == IDLE) ? bad_now          : bad_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt <= 4'd1) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      lane_q  <= 4'b0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == RESP);
      busy  <= (state_nxt != IDLE);
      err   <= (state_nxt == RESP) && acc_bad;

      if (state == IDLE && req) begin
        wr_q    <= wr;
        bad_q   <= bad_now;
        idx_q   <= addr[ADDR_W+1:2];
        wdata_q <= wdata;
        lane_q  <= lane_now;
        cnt     <= WAIT_LD;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (state_nxt == RESP && !acc_wr && !acc_bad)
        rdata <= mem[acc_idx];
    end
  end

  // Write commits on the edge leaving RESP. An asynchronous reset forces
  // IDLE before that edge, so an aborted write never lands.
  always_ff @(posedge clock) begin
    if (state == RESP && wr_q && !bad_q) begin
      for (int i = 0; i < 4; i++)
        if (lane_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int ADDR_W      = 8;
  localparam int WAIT_CYCLES = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;
`ifdef MEM_RESPONDER_BYTE_EN
  logic [3:0]  be;
`endif

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
`ifdef MEM_RESPONDER_BYTE_EN
    .be    (be),
`endif
    .rdata (rdata),
    .ready (ready),
    .err   (err),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [2**ADDR_W];
  logic [31:0] model_rdata;

  // Scoreboard: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rdata", rdata, e.rdata);
        check("err", {31'b0, err}, {31'b0, e.err});
      end
    end
  end

  function automatic logic model_bad(input logic [31:0] a, input logic [3:0] b);
`ifdef MEM_RESPONDER_BYTE_EN
    if (b == 4'b1111 && a[1:0] == 2'b00) return 1'b0;
    if ((b == 4'b0011 || b == 4'b1100) && !a[0]) return 1'b0;
    if (b == (4'b0001 << a[1:0])) return 1'b0;
    return 1'b1;
`else
    return (b != b) || (a[1:0] != 2'b00);
`endif
  endfunction

  // Model the effect of a request and push what the response must look like.
  task automatic expect_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b);
    logic              bad;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        lanes;
    bad = model_bad(a, b);
    idx = a[ADDR_W+1:2];
`ifdef MEM_RESPONDER_BYTE_EN
    lanes = b;
`else
    lanes = 4'b1111;
`endif
    if (!w && !bad) model_rdata = model_mem[idx];
    if (w && !bad)
      for (int i = 0; i < 4; i++)
        if (lanes[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
    sb.push_back('{rdata: model_rdata, err: bad});
  endtask

  task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
`ifdef MEM_RESPONDER_BYTE_EN
    be    = b;
`else
    if (b == 4'b0) wdata = d;
`endif
  endtask

  // One full transaction: accept, measure latency, confirm single-cycle ready.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b);
    bit seen;
    seen = 1'b0;
    expect_req(w, a, d, b);
    @(negedge clock);
    drive(w, a, d, b);
    @(posedge clock);
    #1 req = 1'b0;
    for (int n = 1; n <= WAIT_CYCLES + 6; n++) begin
      @(negedge clock);
      if (n == 1) check("busy_after_accept", {31'b0, busy}, 32'd1);
      if (ready) begin
        check("latency", n, WAIT_CYCLES + 1);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clock);
    check("ready_one_cycle", {31'b0, ready}, 32'd0);
    check("busy_cleared", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t_first;
    int t_second;
    int seen;

    reset = 1'b0;
    req   = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
`ifdef MEM_RESPONDER_BYTE_EN
    be    = 4'b1111;
`endif
    model_rdata = '0;
    for (int i = 0; i < 2**ADDR_W; i++) model_mem[i] = 'x;

    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b1;

    // Basic write then read-back.
    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF);

    // Misaligned read and write: err, rdata and memory untouched.
    xfer(1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF);
    xfer(1'b0, 32'h0000_0402, 32'h0, 4'hF);
    xfer(1'b1, 32'h0000_0401, 32'hFFFF_FFFF, 4'hF);
    xfer(1'b0, 32'h0000_0400, 32'h0, 4'hF);

    // Address wrap modulo the array depth.
    xfer(1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 4'hF);
    xfer(1'b0, 32'h0000_0004, 32'h0, 4'hF);

    // Reset during WAIT aborts a write.
    xfer(1'b1, 32'h0000_0040, 32'h1111_1111, 4'hF);
    @(negedge clock);
    drive(1'b1, 32'h0000_0040, 32'h2222_2222, 4'hF);
    @(posedge clock);
    #1 req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_ready", {31'b0, ready}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    model_rdata = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    xfer(1'b0, 32'h0000_0040, 32'h0, 4'hF);

    // req held high: second request accepted only after returning to IDLE.
    expect_req(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    expect_req(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    @(negedge clock);
    drive(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    t_first = 0;
    t_second = 0;
    seen = 0;
    for (int n = 1; n <= 40 && seen < 2; n++) begin
      @(negedge clock);
      if (ready) begin
        if (seen == 0) t_first = n;
        else begin
          t_second = n;
          req = 1'b0;
        end
        seen++;
      end
    end
    req = 1'b0;
    check("held_req_count", seen, 32'd2);
    check("held_req_spacing", t_second - t_first, WAIT_CYCLES + 2);
    repeat (3) @(negedge clock);

`ifdef MEM_RESPONDER_BYTE_EN
    // Byte-lane write merges into the existing word.
    xfer(1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111);
    xfer(1'b1, 32'h0000_0022, 32'h00AB_0000, 4'b0100);
    xfer(1'b0, 32'h0000_0020, 32'h0, 4'b1111);
    // Half-word enable at an odd offset is illegal.
    xfer(1'b1, 32'h0000_0021, 32'hFFFF_FFFF, 4'b0011);
    xfer(1'b0, 32'h0000_0020, 32'h0, 4'b1111);
`endif

    repeat (2) @(negedge clock);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
